// File: rtl/input_vc_buffer_pkg.sv
// Shared constants and types for the input VC buffer: route codes, flit types, FSM states.
package input_vc_buffer_pkg;

    localparam int unsigned MSB_SLOT   = 5;
    localparam int unsigned DSIZE      = 1 << MSB_SLOT;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned NUM_VC     = 5;

    localparam logic [2:0] RouteN       = 3'd0;
    localparam logic [2:0] RouteS       = 3'd1;
    localparam logic [2:0] RouteE       = 3'd2;
    localparam logic [2:0] RouteW       = 3'd3;
    localparam logic [2:0] RouteL       = 3'd4;
    localparam logic [2:0] RouteInvalid = 3'd7;

    typedef enum logic [1:0] {
        FlitIllegal = 2'b00,
        FlitBody    = 2'b01,
        FlitTail    = 2'b10,
        FlitHead    = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StLocked,
        StDrop
    } vc_state_e;

    function automatic flit_type_e get_flit_type(input logic [1:0] type_bits);
        return flit_type_e'(type_bits);
    endfunction

    function automatic logic route_is_valid(input logic [2:0] route);
        return route <= RouteL;
    endfunction

endpackage

// File: rtl/input_vc_buffer_vc_fifo.sv
// Synchronous first-word-fall-through FIFO; empty/full are registered from the next count.
module vc_fifo #(
    parameter int unsigned DSIZE      = 32,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [DSIZE-1:0] din_i,
    input  logic             rd_en_i,
    output logic [DSIZE-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

    logic [DSIZE-1:0]      mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, full_q;
    logic                  do_wr, do_rd;

    // Full gating uses the pre-read state: no write bypass on a simultaneous pop.
    assign do_wr = wr_en_i && !full_q;
    assign do_rd = rd_en_i && !empty_q;

    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DepthCnt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/input_vc_buffer.sv
// Per-port VC buffer: wormhole packet FSM steers accepted flits into one of five VC FIFOs.
module input_vc_buffer
    import input_vc_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DSIZE-1:0]        data_in,
    input  logic                    valid_in,
    input  logic [2:0]              vc_select,
    output logic                    ready_out,
    input  logic [NUM_VC-1:0]       rd_en,
    output logic [NUM_VC*DSIZE-1:0] data_out,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic                    err_drop
);

    vc_state_e         state_q, state_d;
    logic [2:0]        lock_vc_q, lock_vc_d;
    logic              err_drop_q;
    logic [NUM_VC-1:0] wr_en;
    logic              accept;
    logic              drop;
    flit_type_e        ftype;

    assign ftype = get_flit_type(data_in[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lock_vc_q  <= RouteN;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_vc_q  <= lock_vc_d;
            err_drop_q <= drop;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (ftype == FlitHead) begin
                        if (route_is_valid(vc_select)) begin
                            state_d   = StLocked;
                            lock_vc_d = vc_select;
                        end else begin
                            state_d = StDrop;
                        end
                    end
                end
                StLocked: begin
                    if (ftype == FlitTail) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (ftype == FlitTail) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Discarded flits are always accepted so an orphan or bad packet cannot stall the port.
    always_comb begin
        ready_out = 1'b1;
        wr_en     = '0;
        drop      = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ftype == FlitHead && route_is_valid(vc_select)) begin
                    ready_out        = !full[vc_select];
                    accept           = valid_in && ready_out;
                    wr_en[vc_select] = accept;
                end else begin
                    accept = valid_in;
                    drop   = accept;
                end
            end
            StLocked: begin
                if (ftype == FlitIllegal) begin
                    accept = valid_in;
                    drop   = accept;
                end else begin
                    ready_out        = !full[lock_vc_q];
                    accept           = valid_in && ready_out;
                    wr_en[lock_vc_q] = accept;
                end
            end
            default: begin
                accept = valid_in;
                drop   = accept;
            end
        endcase
    end

    assign err_drop = err_drop_q;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo #(
            .DSIZE      (DSIZE),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_fifo (
            .clk_i   (clk),
            .reset_i (reset),
            .wr_en_i (wr_en[v]),
            .din_i   (data_in),
            .rd_en_i (rd_en[v]),
            .dout_o  (data_out[v*DSIZE +: DSIZE]),
            .empty_o (empty[v]),
            .full_o  (full[v])
        );
    end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer with a queue-based packet model checked every cycle.
module tb_input_vc_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  data_in;
    logic         valid_in;
    logic [2:0]   vc_select;
    logic         ready_out;
    logic [4:0]   rd_en;
    logic [159:0] data_out;
    logic [4:0]   empty;
    logic [4:0]   full;
    logic         err_drop;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    input_vc_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .vc_select (vc_select),
        .ready_out (ready_out),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    // Model: one queue per VC, packet mode 0 idle / 1 locked / 2 dropping.
    logic [31:0] m_q [5][$];
    int          m_mode = 0;
    int          m_lock = 0;
    bit          m_err  = 1'b0;
    int          m_tgt;
    bit          m_drop;
    bit          m_acc;

    function automatic bit model_ready();
        logic [1:0] t = data_in[1:0];
        if (m_mode == 0) begin
            if (t == 2'b11 && vc_select <= 3'd4) return m_q[vc_select].size() < 4;
            return 1'b1;
        end
        if (m_mode == 1) begin
            if (t == 2'b00) return 1'b1;
            return m_q[m_lock].size() < 4;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < 5; v++) m_q[v].delete();
            m_mode = 0;
            m_err  = 1'b0;
        end else begin
            m_acc  = valid_in && model_ready();
            m_tgt  = -1;
            m_drop = 1'b0;
            if (m_acc) begin
                case (m_mode)
                    0: begin
                        if (data_in[1:0] == 2'b11 && vc_select <= 3'd4) begin
                            m_tgt  = int'(vc_select);
                            m_lock = int'(vc_select);
                            m_mode = 1;
                        end else begin
                            m_drop = 1'b1;
                            if (data_in[1:0] == 2'b11) m_mode = 2;
                        end
                    end
                    1: begin
                        if (data_in[1:0] == 2'b00) m_drop = 1'b1;
                        else begin
                            m_tgt = m_lock;
                            if (data_in[1:0] == 2'b10) m_mode = 0;
                        end
                    end
                    default: begin
                        m_drop = 1'b1;
                        if (data_in[1:0] == 2'b10) m_mode = 0;
                    end
                endcase
            end
            for (int v = 0; v < 5; v++) begin
                if (rd_en[v] && m_q[v].size() > 0) void'(m_q[v].pop_front());
            end
            if (m_tgt >= 0) m_q[m_tgt].push_back(data_in);
            m_err = m_drop;
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int v = 0; v < 5; v++) begin
                logic [31:0] exp_d;
                exp_d = (m_q[v].size() > 0) ? m_q[v][0] : 32'h0;
                check($sformatf("data_out[%0d]", v), 160'(data_out[v*32 +: 32]), 160'(exp_d));
                check($sformatf("empty[%0d]", v), 160'(empty[v]), 160'(m_q[v].size() == 0));
                check($sformatf("full[%0d]", v), 160'(full[v]), 160'(m_q[v].size() == 4));
            end
            check("ready_out", 160'(ready_out), 160'(model_ready()));
            check("err_drop", 160'(err_drop), 160'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] vc);
        data_in   = d;
        vc_select = vc;
        valid_in  = 1'b1;
        cyc();
        valid_in  = 1'b0;
        data_in   = '0;
        vc_select = '0;
    endtask

    task automatic pop(input logic [4:0] mask, input int n);
        rd_en = mask;
        repeat (n) cyc();
        rd_en = '0;
    endtask

    initial begin
        reset     = 1'b1;
        data_in   = '0;
        valid_in  = 1'b0;
        vc_select = '0;
        rd_en     = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        check("reset empty", 160'(empty), 160'(5'h1f));
        check("reset full", 160'(full), 160'(5'h00));
        check("reset err_drop", 160'(err_drop), 160'(1'b0));

        // Packet to E: three flits in FIFO 2.
        send(32'hA000_0003, 3'd2);
        send(32'hA000_0101, 3'd0);
        send(32'hA000_0202, 3'd0);
        check("pkt E empty", 160'(empty), 160'(5'b11011));
        check("pkt E head", 160'(data_out[64 +: 32]), 160'(32'hA000_0003));
        check("pkt E err", 160'(err_drop), 160'(1'b0));
        pop(5'b00100, 3);
        check("pkt E drained", 160'(empty), 160'(5'h1f));

        // INVALID head: whole packet dropped.
        send(32'hB000_0003, 3'd7);
        check("inv head err", 160'(err_drop), 160'(1'b1));
        send(32'hB000_0101, 3'd0);
        check("inv body err", 160'(err_drop), 160'(1'b1));
        send(32'hB000_0202, 3'd0);
        check("inv tail err", 160'(err_drop), 160'(1'b1));
        check("inv empty", 160'(empty), 160'(5'h1f));

        // Orphan body in IDLE, then a packet to L.
        send(32'hC000_0101, 3'd0);
        check("orphan err", 160'(err_drop), 160'(1'b1));
        send(32'hC000_0003, 3'd4);
        send(32'hC000_0102, 3'd0);
        check("pkt L empty", 160'(empty), 160'(5'b01111));
        check("pkt L head", 160'(data_out[128 +: 32]), 160'(32'hC000_0003));
        pop(5'b10000, 2);

        // Fill FIFO 0, hold a fifth flit until a pop frees space.
        send(32'hD000_0003, 3'd0);
        send(32'hD000_0101, 3'd0);
        send(32'hD000_0201, 3'd0);
        send(32'hD000_0301, 3'd0);
        data_in  = 32'hD000_0401;
        valid_in = 1'b1;
        cyc();
        check("fill full0", 160'(full[0]), 160'(1'b1));
        check("fill ready", 160'(ready_out), 160'(1'b0));
        rd_en = 5'b00001;
        cyc();
        rd_en = '0;
        check("fill ready after pop", 160'(ready_out), 160'(1'b1));
        check("fill head after pop", 160'(data_out[0 +: 32]), 160'(32'hD000_0101));
        cyc();
        valid_in = 1'b0;
        data_in  = '0;
        check("fill refilled", 160'(full[0]), 160'(1'b1));
        pop(5'b00001, 4);
        send(32'hD000_0502, 3'd0);
        pop(5'b00001, 1);

        // FIFO 1: simultaneous push and pop, then wrap with six flits total.
        send(32'hE000_0003, 3'd1);
        send(32'hE000_0101, 3'd0);
        rd_en = 5'b00010;
        send(32'hE000_0201, 3'd0);
        rd_en = '0;
        check("rw head", 160'(data_out[32 +: 32]), 160'(32'hE000_0101));
        check("rw not full", 160'(full[1]), 160'(1'b0));
        send(32'hE000_0301, 3'd0);
        rd_en = 5'b00010;
        send(32'hE000_0401, 3'd0);
        rd_en = '0;
        send(32'hE000_0502, 3'd0);
        check("wrap full", 160'(full[1]), 160'(1'b1));
        check("wrap head", 160'(data_out[32 +: 32]), 160'(32'hE000_0201));
        pop(5'b00010, 4);
        check("wrap drained", 160'(empty), 160'(5'h1f));

        // Reset mid-packet to W; trailing tail becomes an orphan.
        send(32'hF000_0003, 3'd3);
        send(32'hF000_0101, 3'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst empty", 160'(empty), 160'(5'h1f));
        send(32'hF000_0202, 3'd0);
        check("midrst tail err", 160'(err_drop), 160'(1'b1));
        send(32'h1234_5603, 3'd3);
        check("midrst new head", 160'(data_out[96 +: 32]), 160'(32'h1234_5603));
        send(32'h1234_5602, 3'd0);
        pop(5'b01000, 2);
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
